pipe_ctrl: RTL and testbench

Pipeline stall controller for the five-stage core. Merges stall requests from ID (load-use), EX (single-cycle and multi-cycle operations) and MEM (bus wait) into the 6-bit `stall` vector that freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It owns a small FSM and down-counter that hold EX for a programmed number of cycles on multi-cycle operations such as divide and madd/msub. It also keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_ctrl.sv | 103 ++++++++++
 tb/tb_pipe_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline stall controller: merges ID/EX/MEM stall requests into the stall vector,
// holds EX for multi-cycle operations and counts stalled cycles.
module pipe_ctrl #(
  parameter int unsigned MAXW   = 6,
  parameter int unsigned PERF_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stallreq_from_id,
  input  logic            stallreq_from_ex,
  input  logic            stallreq_from_mem,
  input  logic            ex_multi_start,
  input  logic [MAXW-1:0] ex_multi_len,
  input  logic            flush,
  input  logic            perf_clr,
  output logic [5:0]      stall,
  output logic            ex_busy_o,
  output logic            ex_ready_o,
  output logic [31:0]     stall_cycles_o
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [MAXW-1:0]   cnt_q, cnt_d;
  logic [PERF_W-1:0] perf_q;
  logic              accept;

  // Everything is masked while reset is held low.
  always_comb begin
    accept     = rst && (state_q == StIdle) && ex_multi_start && !flush &&
                 (ex_multi_len != '0);
    ex_busy_o  = rst && (state_q == StBusy);
    ex_ready_o = rst && (state_q == StDone);
    stall      = 6'b000000;
    if (rst) begin
      if (stallreq_from_mem) begin
        stall = 6'b011111;
      end else if (stallreq_from_ex || ex_busy_o || accept) begin
        stall = 6'b001111;
      end else if (stallreq_from_id) begin
        stall = 6'b000111;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (ex_multi_len == MAXW'(1)) begin
            state_d = StDone;
          end else begin
            state_d = StBusy;
            cnt_d   = ex_multi_len - MAXW'(1);
          end
        end
      end
      StBusy: begin
        // A MEM stall freezes the countdown.
        if (!stall[4]) begin
          if (cnt_q == MAXW'(1)) begin
            state_d = StDone;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - MAXW'(1);
          end
        end
      end
      StDone: begin
        if (!stall[3]) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d = StIdle;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      perf_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (perf_clr) begin
        perf_q <= '0;
      end else if (stall[0] && (perf_q != '1)) begin
        perf_q <= perf_q + PERF_W'(1);
      end
    end
  end

  assign stall_cycles_o = 32'(perf_q);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: priority table, directed multi-cycle sequences and
// randomized traffic against a cycle-count reference model.
module tb_pipe_ctrl;

  localparam int unsigned PerfW   = 8;
  localparam int unsigned PerfMax = (1 << PerfW) - 1;

  logic        clk;
  logic        rst;
  logic        id_req, ex_req, mem_req;
  logic        start;
  logic [5:0]  len;
  logic        flush;
  logic        perf_clr;
  logic [5:0]  stall;
  logic        busy, ready;
  logic [31:0] stall_cycles;

  int errors = 0;
  int checks = 0;

  pipe_ctrl #(.MAXW(6), .PERF_W(PerfW)) dut (
    .clk               (clk),
    .rst               (rst),
    .stallreq_from_id  (id_req),
    .stallreq_from_ex  (ex_req),
    .stallreq_from_mem (mem_req),
    .ex_multi_start    (start),
    .ex_multi_len      (len),
    .flush             (flush),
    .perf_clr          (perf_clr),
    .stall             (stall),
    .ex_busy_o         (busy),
    .ex_ready_o        (ready),
    .stall_cycles_o    (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: remaining hold cycles plus a pending-result flag.
  int          m_hold;
  bit          m_rdy;
  int unsigned m_perf;
  logic [5:0]  m_stall;
  logic        m_busy, m_ready, m_accept;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_eval();
    m_busy   = rst && (m_hold > 0);
    m_ready  = rst && m_rdy;
    m_accept = rst && (m_hold == 0) && !m_rdy && start && !flush && (len != 0);
    if (!rst)                               m_stall = 6'b000000;
    else if (mem_req)                       m_stall = 6'b011111;
    else if (ex_req || m_busy || m_accept)  m_stall = 6'b001111;
    else if (id_req)                        m_stall = 6'b000111;
    else                                    m_stall = 6'b000000;
  endtask

  task automatic model_tick();
    if (!rst) begin
      m_hold = 0;
      m_rdy  = 0;
      m_perf = 0;
    end else begin
      if (perf_clr) m_perf = 0;
      else if (m_stall[0] && m_perf < PerfMax) m_perf++;
      if (flush) begin
        m_hold = 0;
        m_rdy  = 0;
      end else if (m_rdy) begin
        m_rdy = m_stall[3];
      end else if (m_hold > 0) begin
        if (!mem_req) begin
          m_hold--;
          if (m_hold == 0) m_rdy = 1;
        end
      end else if (m_accept) begin
        m_hold = int'(len) - 1;
        if (m_hold == 0) m_rdy = 1;
      end
    end
  endtask

  // Sample at the falling edge and compare everything against the model.
  task automatic at_neg();
    @(negedge clk);
    model_eval();
    chk("stall", 32'(stall), 32'(m_stall));
    chk("ex_busy", 32'(busy), 32'(m_busy));
    chk("ex_ready", 32'(ready), 32'(m_ready));
    chk("stall_cycles", stall_cycles, m_perf);
  endtask

  task automatic to_pos();
    model_eval();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic idle_inputs();
    id_req = 0; ex_req = 0; mem_req = 0; start = 0; len = '0; flush = 0; perf_clr = 0;
  endtask

  typedef struct {
    logic       rst_n, id, ex, mem;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[8];
  logic [31:0] p0;
  bit saw_ready;

  initial begin
    vecs[0] = '{1, 1, 0, 0, 6'b000111};
    vecs[1] = '{1, 1, 1, 0, 6'b001111};
    vecs[2] = '{1, 1, 1, 1, 6'b011111};
    vecs[3] = '{1, 0, 0, 0, 6'b000000};
    vecs[4] = '{1, 0, 1, 0, 6'b001111};
    vecs[5] = '{1, 0, 0, 1, 6'b011111};
    vecs[6] = '{0, 1, 1, 1, 6'b000000};
    vecs[7] = '{0, 1, 1, 0, 6'b000000};

    m_hold = 0; m_rdy = 0; m_perf = 0;
    idle_inputs();
    rst = 0;
    to_pos();
    to_pos();
    at_neg();
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_perf", stall_cycles, 32'd0);
    to_pos();
    rst = 1;

    // Request priority table
    foreach (vecs[i]) begin
      rst = vecs[i].rst_n; id_req = vecs[i].id; ex_req = vecs[i].ex; mem_req = vecs[i].mem;
      at_neg();
      chk($sformatf("prio[%0d]", i), 32'(stall), 32'(vecs[i].exp));
      to_pos();
    end
    rst = 1;
    idle_inputs();
    to_pos();

    // Reset mid-BUSY
    start = 1; len = 6'd5;
    at_neg(); to_pos();
    start = 0;
    at_neg(); chk("rst_busy_before", 32'(busy), 32'd1); to_pos();
    rst = 0;
    at_neg(); chk("rst_mask_stall", 32'(stall), 32'd0); to_pos();
    rst = 1;
    at_neg();
    chk("rst_idle_busy", 32'(busy), 32'd0);
    chk("rst_idle_stall", 32'(stall), 32'd0);
    chk("rst_idle_perf", stall_cycles, 32'd0);
    to_pos();

    // Length 4 sequence
    start = 1; len = 6'd4;
    p0 = stall_cycles;
    for (int k = 0; k <= 5; k++) begin
      at_neg();
      chk($sformatf("len4_stall[%0d]", k), 32'(stall), (k < 4) ? 32'h0F : 32'h00);
      chk($sformatf("len4_busy[%0d]", k), 32'(busy), 32'((k >= 1) && (k <= 3)));
      chk($sformatf("len4_ready[%0d]", k), 32'(ready), 32'(k == 4));
      if (k == 4) chk("len4_perf", stall_cycles, p0 + 32'd4);
      to_pos();
      start = 0;
    end

    // Length 0 ignored, length 1 ready next cycle
    start = 1; len = 6'd0;
    at_neg(); chk("len0_stall", 32'(stall), 32'd0); to_pos();
    start = 0;
    at_neg(); chk("len0_ready", 32'(ready), 32'd0); to_pos();
    start = 1; len = 6'd1;
    at_neg(); chk("len1_stall", 32'(stall), 32'h0F); to_pos();
    start = 0;
    at_neg(); chk("len1_ready", 32'(ready), 32'd1); chk("len1_busy", 32'(busy), 32'd0);
    to_pos();
    at_neg(); chk("len1_idle", 32'(ready), 32'd0); to_pos();

    // MEM freeze during BUSY
    start = 1; len = 6'd3;
    for (int k = 0; k <= 6; k++) begin
      mem_req = (k == 1 || k == 2);
      at_neg();
      chk($sformatf("mem_stall[%0d]", k), 32'(stall),
          (k == 1 || k == 2) ? 32'h1F : (k <= 4) ? 32'h0F : 32'h00);
      chk($sformatf("mem_ready[%0d]", k), 32'(ready), 32'(k == 5));
      to_pos();
      start = 0;
    end
    mem_req = 0;

    // Flush mid-sequence, then start coincident with flush
    start = 1; len = 6'd32;
    saw_ready = 0;
    for (int k = 0; k <= 14; k++) begin
      flush = (k == 10);
      at_neg();
      if (ready) saw_ready = 1;
      if (k == 11) begin
        chk("flush_stall", 32'(stall), 32'd0);
        chk("flush_busy", 32'(busy), 32'd0);
      end
      to_pos();
      start = 0;
    end
    chk("flush_no_ready", 32'(saw_ready), 32'd0);
    start = 1; flush = 1; len = 6'd3;
    at_neg(); chk("flush_start_stall", 32'(stall), 32'd0); to_pos();
    start = 0; flush = 0;
    at_neg(); chk("flush_start_busy", 32'(busy), 32'd0); to_pos();

    // Perf counter saturation (reduced width) and clear-beats-increment
    id_req = 1;
    for (int k = 0; k < PerfMax + 10; k++) to_pos();
    at_neg(); chk("perf_sat", stall_cycles, 32'(PerfMax)); to_pos();
    perf_clr = 1;
    at_neg(); to_pos();
    perf_clr = 0;
    at_neg(); chk("perf_clr", stall_cycles, 32'd0); to_pos();
    idle_inputs();

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      rst      = ($urandom_range(199) != 0);
      id_req   = ($urandom_range(4) == 0);
      ex_req   = ($urandom_range(9) == 0);
      mem_req  = ($urandom_range(5) == 0);
      start    = ($urandom_range(5) == 0);
      len      = ($urandom_range(7) == 0) ? 6'($urandom_range(63)) : 6'($urandom_range(6));
      flush    = ($urandom_range(39) == 0);
      perf_clr = ($urandom_range(149) == 0);
      at_neg();
      to_pos();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
